// File: rtl/glitch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : glitch_pkg
// Purpose  : Shared types and default sizes for the glitch pulse train.
//            Holds the phase state enumeration and the default operand and
//            counter widths used by glitch_pulse_train.
// Revision : 1.0  initial release
// ============================================================================
package glitch_pkg;

  // Default width of the delay/width/gap operands and the phase counter
  localparam int DEF_CNT_W = 32;
  // Default width of the pulse-count operand
  localparam int DEF_NUM_W = 8;

  // Train phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ON    = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage : glitch_pkg
`default_nettype wire

// File: rtl/glitch_pulse_train_phase_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : phase_down_counter
// Purpose  : Loadable saturating down-counter timing one train phase.
//            A load takes priority over a decrement; a decrement at zero
//            holds the count at zero.
// Ports    : clk       - clock, posedge
//            reset     - asynchronous active-high reset, clears the count
//            load      - load load_val on the next edge
//            load_val  - value to load
//            dec       - decrement on the next edge (saturating at zero)
//            zero      - count is zero
// Revision : 1.0  initial release
// ============================================================================
module phase_down_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule : phase_down_counter
`default_nettype wire

// File: rtl/glitch_pulse_train.sv
`default_nettype none
// ============================================================================
// Module   : glitch_pulse_train
// Purpose  : Generates a train of active-low glitch pulses with programmable
//            start delay, pulse width, inter-pulse gap and pulse count.
//            Width, gap and count are latched when a train starts, so the
//            host may change them while a train runs. Zero width, gap or
//            count is treated as one.
// Ports    : clk        - clock, posedge
//            reset      - asynchronous active-high reset
//            start      - one-cycle request, honoured only when idle
//            delay      - cycles from start edge to first falling edge
//            width      - low time per pulse in cycles
//            gap        - high time between pulses in cycles
//            num        - pulses per train
//            abort      - abandon the running train (GLITCH_ABORT_EN only)
//            active_low - glitch output, 0 = glitch on
//            busy       - train in progress
//            done       - one-cycle strobe at train completion
// Config   : GLITCH_ABORT_EN - when defined, adds the abort input.
// Revision : 1.0  initial release
// ============================================================================
module glitch_pulse_train
  import glitch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef GLITCH_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [NUM_W-1:0] num,
  output logic             active_low,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q,   gap_d;
  logic [NUM_W-1:0] left_q,  left_d;
  logic             active_low_q, active_low_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;

  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_abort;

  logic [CNT_W-1:0] w_width_eff;
  logic [CNT_W-1:0] w_gap_eff;
  logic [NUM_W-1:0] w_num_eff;

`ifdef GLITCH_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Zero operands collapse to one so every phase lasts at least a cycle
  assign w_width_eff = (width == '0) ? CNT_W'(1) : width;
  assign w_gap_eff   = (gap   == '0) ? CNT_W'(1) : gap;
  assign w_num_eff   = (num   == '0) ? NUM_W'(1) : num;

  phase_down_counter #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    gap_d        = gap_q;
    left_d       = left_q;
    active_low_d = active_low_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_cnt_dec    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          width_d = w_width_eff;
          gap_d   = w_gap_eff;
          left_d  = w_num_eff;
          busy_d  = 1'b1;
          w_cnt_load = 1'b1;
          if (delay == '0) begin
            // No delay: the first pulse begins on the start edge itself
            state_d      = ON;
            active_low_d = 1'b0;
            w_cnt_val    = w_width_eff - CNT_W'(1);
          end else begin
            state_d   = DELAY;
            w_cnt_val = delay - CNT_W'(1);
          end
        end
      end

      DELAY, GAP: begin
        if (w_cnt_zero) begin
          state_d      = ON;
          active_low_d = 1'b0;
          w_cnt_load   = 1'b1;
          w_cnt_val    = width_q - CNT_W'(1);
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      ON: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else if (left_q > NUM_W'(1)) begin
          state_d      = GAP;
          active_low_d = 1'b1;
          left_d       = left_q - NUM_W'(1);
          w_cnt_load   = 1'b1;
          w_cnt_val    = gap_q - CNT_W'(1);
        end else begin
          state_d      = IDLE;
          active_low_d = 1'b1;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        active_low_d = 1'b1;
        busy_d       = 1'b0;
      end
    endcase

    // Abort overrides whatever phase transition was computed above
    if (w_abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      active_low_d = 1'b1;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      w_cnt_load   = 1'b1;
      w_cnt_val    = '0;
      w_cnt_dec    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      width_q      <= '0;
      gap_q        <= '0;
      left_q       <= '0;
      active_low_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      gap_q        <= gap_d;
      left_q       <= left_d;
      active_low_q <= active_low_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign active_low = active_low_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : glitch_pulse_train
`default_nettype wire

// File: tb/tb_glitch_pulse_train.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitch_pulse_train
// Purpose  : Self-checking bench for glitch_pulse_train. The expected output
//            waveform is computed from the start edge and the latched train
//            parameters with plain arithmetic (offset into the train modulo
//            the pulse period).
// Config   : GLITCH_ABORT_EN - when defined, the abort input is exercised.
// Revision : 1.0  initial release
// ============================================================================
module tb_glitch_pulse_train;

  localparam int CNT_W = 32;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  logic [NUM_W-1:0] num;
  logic             active_low;
  logic             busy;
  logic             done;
`ifdef GLITCH_ABORT_EN
  logic             abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit     have_train = 1'b0;
  longint cyc = 0;
  longint k_start = 0;
  longint m_d = 0, m_w = 1, m_g = 1, m_n = 1, m_e = 0;
  bit     e_al = 1'b1, e_busy = 1'b0, e_done = 1'b0;

  always #5 clk = ~clk;

  glitch_pulse_train #(
    .CNT_W (CNT_W),
    .NUM_W (NUM_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef GLITCH_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .delay      (delay),
    .width      (width),
    .gap        (gap),
    .num        (num),
    .active_low (active_low),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint eff(input longint v);
    return (v == 0) ? 1 : v;
  endfunction

  // Expected outputs after the current edge, from the train's time offset
  task automatic compute_expected();
    longint t, u;
    if (!have_train) begin
      e_al = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      t      = cyc - k_start;
      e_busy = (t < m_e);
      e_done = (t == m_e);
      if (t < m_d || t >= m_e) begin
        e_al = 1'b1;
      end else begin
        u    = t - m_d;
        e_al = !((u % (m_w + m_g)) < m_w);
      end
    end
  endtask

  // One clock edge: update the model with the inputs seen at the edge,
  // then check the outputs shortly after it
  task automatic step();
    longint t;
    bit idle, ab;
    @(posedge clk);
    cyc++;
    t    = cyc - k_start;
    idle = !have_train || (t >= m_e + 1);
    ab   = 1'b0;
`ifdef GLITCH_ABORT_EN
    ab = abort && have_train && (t >= 1) && (t <= m_e);
`endif
    if (ab) begin
      have_train = 1'b0;
    end else if (start && idle) begin
      have_train = 1'b1;
      k_start    = cyc;
      m_d        = longint'(delay);
      m_w        = eff(longint'(width));
      m_g        = eff(longint'(gap));
      m_n        = eff(longint'(num));
      m_e        = m_d + m_n * m_w + (m_n - 1) * m_g;
    end
    #1;
    compute_expected();
    chk("active_low", {63'd0, active_low}, {63'd0, e_al});
    chk("busy",       {63'd0, busy},       {63'd0, e_busy});
    chk("done",       {63'd0, done},       {63'd0, e_done});
  endtask

  task automatic scramble_operands();
    delay = CNT_W'($urandom_range(0, 6));
    width = CNT_W'($urandom_range(0, 5));
    gap   = CNT_W'($urandom_range(0, 5));
    num   = NUM_W'($urandom_range(0, 4));
  endtask

  // Pulse start with the given operands, then change them to show latching
  task automatic launch(input int d, input int w, input int g, input int n);
    delay = CNT_W'(d);
    width = CNT_W'(w);
    gap   = CNT_W'(g);
    num   = NUM_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    scramble_operands();
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!e_done && i < budget) begin
      step();
      i++;
    end
    chk("done_timeout", {63'd0, e_done}, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    delay = '0;
    width = '0;
    gap   = '0;
    num   = '0;
`ifdef GLITCH_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk("rst_active_low", {63'd0, active_low}, 64'd1);
    chk("rst_busy",       {63'd0, busy},       64'd0);
    chk("rst_done",       {63'd0, done},       64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Minimal train
    launch(0, 1, 1, 1);
    wait_done(20);

    // Three pulses after a delay
    launch(5, 3, 2, 3);
    wait_done(40);

    // All-zero operands behave as one
    launch(0, 0, 0, 0);
    wait_done(20);

    // Start mid-train is ignored; start on the done cycle is accepted
    launch(2, 2, 2, 3);
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40);
    launch(1, 2, 1, 2);
    wait_done(40);

    // Asynchronous reset while the pulse is low
    launch(1, 6, 1, 2);
    step();
    step();
    step();
    chk("pre_reset_low", {63'd0, active_low}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_active_low", {63'd0, active_low}, 64'd1);
    chk("async_rst_busy",       {63'd0, busy},       64'd0);
    chk("async_rst_done",       {63'd0, done},       64'd0);
    have_train = 1'b0;
    #2;
    reset = 1'b0;
    step();

`ifdef GLITCH_ABORT_EN
    // Abort in the second gap of a four-pulse train
    launch(0, 2, 3, 4);
    repeat (8) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_busy", {63'd0, busy}, 64'd0);
    repeat (3) step();
`endif

    // Random traffic: operands change every cycle, start fires often
    for (int i = 0; i < 3000; i++) begin
      scramble_operands();
      start = ($urandom_range(0, 3) == 0);
`ifdef GLITCH_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
      step();
    end
    start = 1'b0;
`ifdef GLITCH_ABORT_EN
    abort = 1'b0;
`endif
    repeat (60) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_glitch_pulse_train
`default_nettype wire
